axi_stream_insert_header_gen2: RTL and testbench
================================================

AXI_STREAM_INSERT_HEADER_GEN2 -- requirements
Module: axi_stream_insert_header_gen2

Interface
REQ-001 Parameter DATA_WD, default 32, stream width in bits; legal values are multiples of 8, from 32 to 512.
REQ-002 Parameter DATA_BYTE_WD, default DATA_WD/8, number of byte lanes (B).
REQ-003 Parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), width of the header byte count.
REQ-004 Parameter CNT_WD, default 16, width of the packet counter.
REQ-005 clk  in  1  sole clock; all logic is rising-edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 valid_in / data_in / keep_in / last_in  in  1/DATA_WD/B/1  payload AXI-Stream slave.
REQ-008 ready_in  out  1  payload slave ready.
REQ-009 valid_out / data_out / keep_out / last_out  out  1/DATA_WD/B/1  header-prefixed AXI-Stream master.
REQ-010 ready_out  in  1  master ready.
REQ-011 valid_insert / data_insert / keep_insert / byte_insert_cnt  in  1/DATA_WD/B/BYTE_CNT_WD  header channel; header length H = byte_insert_cnt+1; the valid bytes are the low H lanes.
REQ-012 ready_insert  out  1  header channel ready.
REQ-013 pkt_cnt  out  CNT_WD  count of completed output packets; wraps to 0 after all-ones.
REQ-014 keep_err  out  1  one-cycle pulse on a malformed payload keep.

Function
REQ-015 Byte order: the MSB lane (lane B-1) is first in time; keep on a last beat is contiguous from the MSB lane.
REQ-016 The FSM has three states: IDLE, STREAM and TAIL; reset enters IDLE.
REQ-017 ready_insert = (state==IDLE); a header handshake latches H and the low H lanes of data_insert into the residual register at its top H lanes, then moves to STREAM.
REQ-018 In STREAM, ready_in = (!valid_out || ready_out); ready_in is 0 in IDLE and TAIL.
REQ-019 The output register loads only when (!valid_out || ready_out); while valid_out && !ready_out, data_out, keep_out and last_out are held stable.
REQ-020 Each accepted non-last beat drives data_out = {residual H bytes, top B-H bytes of data_in} with keep_out all ones; the residual then becomes the low H bytes of data_in.
REQ-021 Last beat, where V is the number of leading ones in keep_in, and H+V <= B: emit one beat with last_out=1 and keep_out = top H+V lanes set, then return to IDLE.
REQ-022 Last beat with H+V > B: emit a full beat with last_out=0, go to TAIL, then emit the residual H+V-B bytes with last_out=1 and the matching MSB-aligned keep, then return to IDLE.
REQ-023 H = B is a pure pass-through after one full header beat; there is no shifting.
REQ-024 Latency is one cycle from the input handshake to valid_out.
REQ-025 A one-cycle gap between packets (the IDLE header cycle) is permitted; an output beat and the next header handshake may coincide.
REQ-026 keep_err pulses for one cycle when a last beat has keep_in == 0 or a non-contiguous keep_in, or when a non-last beat has keep_in != all ones; the beat is processed using V.
REQ-027 pkt_cnt increments on each output handshake with last_out=1.
REQ-028 Bytes outside keep_out are driven 0.

Reset
REQ-029 With rst_n=0 at a clock edge: valid_out, data_out, keep_out, last_out, keep_err and pkt_cnt are 0, the FSM is in IDLE, and the residual register is cleared.
REQ-030 Reset mid-packet discards the packet; the first cycle after reset release has ready_insert=1 and ready_in=0.

Structure
REQ-031 Package axis_hdr_pkg holds the state enum (IDLE, STREAM, TAIL) and the function mapping a byte count to an MSB-aligned keep mask.
REQ-032 Sub-module axis_keep_decode (combinational) produces V and the contiguity flag from keep_in.

Verification
REQ-033 DATA_WD=32, H=2, data_insert=0x0000AABB, beats 0x11223344 then 0x55667788 (last, keep 1111) -> 0xAABB1122, 0x33445566, then 0x77880000 (keep 1100, last); pkt_cnt=1.
REQ-034 H=4, data_insert=0xDEADBEEF, one beat 0x01020304 (last, keep 1111) -> 0xDEADBEEF (keep 1111), then 0x01020304 (keep 1111, last).
REQ-035 H=3, data_insert=0x00A1B2C3, one beat 0x44000000 (last, keep 1000) -> single beat 0xA1B2C344 (keep 1111, last); no TAIL state.
REQ-036 Random ready_out over 50 beats -> outputs are held stable under stall, there is no loss or duplication, and the scoreboard matches.
REQ-037 Last beat with keep 1010 -> keep_err pulses for one cycle; the beat is processed as V=1.
REQ-038 rst_n=0 mid-packet, then a new packet -> all outputs are 0 during reset; the next packet is emitted correctly with pkt_cnt=1; repeat at DATA_WD=64 with H=5.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// +----------------------------------------------------------------------+
// | axis_hdr_pkg: FSM state type and MSB-aligned keep-mask helper        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        TAIL   = 2'd2
    } state_t;

    // Lanes [b-1 : b-n] set; n >= b yields all b lanes. Callers truncate to b bits.
    function automatic logic [63:0] msb_keep(input int unsigned n, input int unsigned b);
        logic [63:0] m;
        m = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if ((i < b) && (i + n >= b)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_keep_decode.sv
// +----------------------------------------------------------------------+
// | axis_keep_decode: leading-ones count and contiguity of a keep vector |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module axis_keep_decode #(
    parameter int DATA_BYTE_WD = 4,
    parameter int LEN_WD       = 4
) (
    input  logic [DATA_BYTE_WD-1:0] i_keep,
    output logic [LEN_WD-1:0]       o_lead_ones,
    output logic                    o_contig
);

    logic w_run;

    // Count ones from the MSB lane until the first zero; any one after that breaks contiguity.
    always_comb begin
        o_lead_ones = '0;
        o_contig    = 1'b1;
        w_run       = 1'b1;
        for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
            if (i_keep[i] && w_run) begin
                o_lead_ones = o_lead_ones + LEN_WD'(1);
            end else if (i_keep[i]) begin
                o_contig = 1'b0;
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_stream_insert_header_gen2.sv
// +----------------------------------------------------------------------+
// | axi_stream_insert_header_gen2: prefixes an H-byte header to a stream |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module axi_stream_insert_header_gen2
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int CNT_WD       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert,
    output logic [CNT_WD-1:0]       pkt_cnt,
    output logic                    keep_err
);

    localparam int c_LEN_WD = BYTE_CNT_WD + 2;
    localparam logic [DATA_BYTE_WD-1:0] c_FULL_KEEP = '1;

    function automatic logic [DATA_WD-1:0] bytes_of(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    state_t r_state, w_next_state;

    logic                    r_valid_out, r_last_out, r_keep_err;
    logic [DATA_WD-1:0]      r_data_out, r_resid;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic [CNT_WD-1:0]       r_pkt_cnt;
    logic [c_LEN_WD-1:0]     r_hdr_len, r_tail_len;

    logic                    w_out_en, w_in_hs, w_hdr_hs, w_pkt_done;
    logic                    w_overflow, w_contig, w_bad_keep, w_unused;
    logic [c_LEN_WD-1:0]     w_v, w_sum, w_rem, w_hdr_len_in, w_hdr_rem;
    logic [DATA_BYTE_WD-1:0] w_keep_v, w_keep_sum, w_keep_tail;
    logic [DATA_WD-1:0]      w_din_sel, w_beat;

    axis_keep_decode #(
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .LEN_WD       (c_LEN_WD)
    ) u_keep_decode (
        .i_keep      (keep_in),
        .o_lead_ones (w_v),
        .o_contig    (w_contig)
    );

    // Header lanes are implied by byte_insert_cnt; keep_insert carries no extra information.
    assign w_unused = ^keep_insert;

    assign w_out_en     = !r_valid_out || ready_out;
    assign w_in_hs      = valid_in && ready_in;
    assign w_hdr_hs     = valid_insert && ready_insert;
    assign w_pkt_done   = r_valid_out && ready_out && r_last_out;

    assign w_hdr_len_in = c_LEN_WD'(byte_insert_cnt) + c_LEN_WD'(1);
    assign w_hdr_rem    = c_LEN_WD'(DATA_BYTE_WD) - w_hdr_len_in;
    assign w_rem        = c_LEN_WD'(DATA_BYTE_WD) - r_hdr_len;
    assign w_sum        = r_hdr_len + w_v;
    assign w_overflow   = w_sum > c_LEN_WD'(DATA_BYTE_WD);

    assign w_keep_v     = DATA_BYTE_WD'(msb_keep(32'(w_v), DATA_BYTE_WD));
    assign w_keep_sum   = DATA_BYTE_WD'(msb_keep(32'(w_sum), DATA_BYTE_WD));
    assign w_keep_tail  = DATA_BYTE_WD'(msb_keep(32'(r_tail_len), DATA_BYTE_WD));

    // A last beat only contributes its V leading lanes, even when keep_in is malformed.
    assign w_din_sel    = last_in ? (data_in & bytes_of(w_keep_v)) : data_in;
    assign w_beat       = r_resid | (w_din_sel >> {r_hdr_len, 3'b000});
    assign w_bad_keep   = last_in ? ((keep_in == '0) || !w_contig) : (keep_in != c_FULL_KEEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        case (r_state)
            IDLE: begin
                ready_insert = 1'b1;
                if (valid_insert) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                ready_in = w_out_en;
                if (valid_in && w_out_en && last_in) begin
                    w_next_state = w_overflow ? TAIL : IDLE;
                end
            end
            TAIL: begin
                if (w_out_en) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
            r_keep_err  <= 1'b0;
            r_pkt_cnt   <= '0;
            r_resid     <= '0;
            r_hdr_len   <= '0;
            r_tail_len  <= '0;
        end else begin
            r_keep_err <= w_in_hs && w_bad_keep;
            if (w_pkt_done) begin
                r_pkt_cnt <= r_pkt_cnt + CNT_WD'(1);
            end
            if (w_hdr_hs) begin
                r_hdr_len <= w_hdr_len_in;
                r_resid   <= data_insert << {w_hdr_rem, 3'b000};
            end
            if (w_out_en) begin
                r_valid_out <= 1'b0;
                if (w_in_hs) begin
                    r_valid_out <= 1'b1;
                    r_resid     <= w_din_sel << {w_rem, 3'b000};
                    if (last_in && !w_overflow) begin
                        r_data_out <= w_beat & bytes_of(w_keep_sum);
                        r_keep_out <= w_keep_sum;
                        r_last_out <= 1'b1;
                    end else begin
                        // Full beat; on an overflowing last beat the spill goes out from TAIL.
                        r_data_out <= w_beat;
                        r_keep_out <= c_FULL_KEEP;
                        r_last_out <= 1'b0;
                        r_tail_len <= w_sum - c_LEN_WD'(DATA_BYTE_WD);
                    end
                end else if (r_state == TAIL) begin
                    r_valid_out <= 1'b1;
                    r_data_out  <= r_resid & bytes_of(w_keep_tail);
                    r_keep_out  <= w_keep_tail;
                    r_last_out  <= 1'b1;
                end
            end
        end
    end

    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;
    assign keep_out  = r_keep_out;
    assign last_out  = r_last_out;
    assign keep_err  = r_keep_err;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_insert_header_gen2.sv
// +----------------------------------------------------------------------+
// | tb_axi_stream_insert_header_gen2: directed + random header insertion |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_axi_stream_insert_header_gen2;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, sel, valid_in, last_in, valid_insert, ready_out;
    logic [63:0] data_in, data_insert;
    logic [7:0]  keep_in, keep_insert;
    logic [2:0]  byte_cnt;

    logic        ri32, rh32, v32, l32, e32, ri64, rh64, v64, l64, e64;
    logic [31:0] d32;
    logic [63:0] d64;
    logic [3:0]  k32;
    logic [7:0]  k64;
    logic [15:0] p32, p64;
    logic        vi32, vi64, vh32, vh64;

    logic        m_ready_in, m_ready_insert, m_vo, m_lo, m_err;
    logic [63:0] m_do;
    logic [7:0]  m_ko;
    logic [15:0] m_pkt;

    assign vi32 = valid_in & ~sel;
    assign vi64 = valid_in & sel;
    assign vh32 = valid_insert & ~sel;
    assign vh64 = valid_insert & sel;

    assign m_ready_in     = sel ? ri64 : ri32;
    assign m_ready_insert = sel ? rh64 : rh32;
    assign m_vo           = sel ? v64 : v32;
    assign m_lo           = sel ? l64 : l32;
    assign m_err          = sel ? e64 : e32;
    assign m_do           = sel ? d64 : {32'd0, d32};
    assign m_ko           = sel ? k64 : {4'd0, k32};
    assign m_pkt          = sel ? p64 : p32;

    axi_stream_insert_header_gen2 #(.DATA_WD(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vi32), .data_in(data_in[31:0]), .keep_in(keep_in[3:0]), .last_in(last_in),
        .ready_in(ri32),
        .valid_out(v32), .data_out(d32), .keep_out(k32), .last_out(l32), .ready_out(ready_out),
        .valid_insert(vh32), .data_insert(data_insert[31:0]), .keep_insert(keep_insert[3:0]),
        .byte_insert_cnt(byte_cnt[1:0]), .ready_insert(rh32),
        .pkt_cnt(p32), .keep_err(e32)
    );

    axi_stream_insert_header_gen2 #(.DATA_WD(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .valid_in(vi64), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ri64),
        .valid_out(v64), .data_out(d64), .keep_out(k64), .last_out(l64), .ready_out(ready_out),
        .valid_insert(vh64), .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_cnt), .ready_insert(rh64),
        .pkt_cnt(p64), .keep_err(e64)
    );

    int          checks = 0;
    int          errors = 0;
    int          nb = 4;
    int          model_cnt = 0;
    int          beats = 0;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;
    bit          exp_err = 1'b0;
    bit          stalled = 1'b0;
    logic [63:0] hold_d;
    logic [7:0]  hold_k;
    logic        hold_l;
    beat_t       exp_q[$];
    logic [7:0]  hdr_q[$];
    logic [7:0]  pay_q[$];

    function automatic logic [7:0] msb_ones(input int v, input int b);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < v; i++) m[b-1-i] = 1'b1;
        return m;
    endfunction

    function automatic int lead_ones(input logic [7:0] k, input int b);
        int n;
        n = 0;
        for (int i = b - 1; i >= 0; i--) begin
            if (!k[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit bad_keep(input logic [7:0] k, input logic l, input int b);
        logic [7:0] km;
        km = k & msb_ones(b, b);
        if (!l) return km != msb_ones(b, b);
        return (km == 8'd0) || (km != msb_ones(lead_ones(km, b), b));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Output stream = header bytes then payload bytes, cut into nb-byte beats, MSB lane first.
    task automatic push_model();
        logic [7:0] all_q[$];
        int         nbeats;
        beat_t      b;
        all_q.delete();
        foreach (hdr_q[i]) all_q.push_back(hdr_q[i]);
        foreach (pay_q[i]) all_q.push_back(pay_q[i]);
        nbeats = (all_q.size() + nb - 1) / nb;
        for (int k = 0; k < nbeats; k++) begin
            b.data = '0;
            b.keep = '0;
            b.last = (k == nbeats - 1);
            for (int j = 0; j < nb; j++) begin
                if (k * nb + j < all_q.size()) begin
                    b.data[8*(nb-1-j) +: 8] = all_q[k*nb+j];
                    b.keep[nb-1-j] = 1'b1;
                end
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_hs(input bit hdr, input string tag);
        bit hs;
        int n;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 500) begin
            @(negedge clk);
            hs = hdr ? m_ready_insert : m_ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk(tag, 64'(hs), 64'd1);
    endtask

    task automatic send_hdr(input logic [63:0] d, input int h);
        data_insert  = d;
        keep_insert  = 8'((1 << h) - 1);
        byte_cnt     = 3'(h - 1);
        valid_insert = 1'b1;
        wait_hs(1'b1, "hdr_timeout");
        valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        valid_in = 1'b1;
        wait_hs(1'b0, "beat_timeout");
        valid_in = 1'b0;
    endtask

    task automatic rand_pkt(input int h_force);
        int          h, n, v;
        logic [63:0] hword;
        logic [63:0] bd[4];
        logic [7:0]  bk[4];
        h = (h_force > 0) ? h_force : int'($urandom_range(1, nb));
        hword = {$urandom, $urandom};
        n = $urandom_range(1, 4);
        hdr_q.delete();
        pay_q.delete();
        for (int j = 0; j < h; j++) hdr_q.push_back(hword[8*(h-1-j) +: 8]);
        for (int b = 0; b < n; b++) begin
            bd[b] = {$urandom, $urandom};
            if (b < n - 1) bk[b] = msb_ones(nb, nb);
            else if ($urandom_range(0, 4) == 0) bk[b] = 8'($urandom) & msb_ones(nb, nb);
            else bk[b] = msb_ones($urandom_range(0, nb), nb);
            v = (b < n - 1) ? nb : lead_ones(bk[b], nb);
            for (int j = 0; j < v; j++) pay_q.push_back(bd[b][8*(nb-1-j) +: 8]);
        end
        push_model();
        send_hdr(hword, h);
        for (int b = 0; b < n; b++) send_beat(bd[b], bk[b], b == n - 1);
        beats += n;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_vo) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_rst_valid"}, 64'(m_vo), 64'd0);
        chk({tag, "_rst_data"}, m_do, 64'd0);
        chk({tag, "_rst_keep"}, 64'(m_ko), 64'd0);
        chk({tag, "_rst_last"}, 64'(m_lo), 64'd0);
        chk({tag, "_rst_err"}, 64'(m_err), 64'd0);
        chk({tag, "_rst_pkt"}, 64'(m_pkt), 64'd0);
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_rel_rdy_ins"}, 64'(m_ready_insert), 64'd1);
        chk({tag, "_rel_rdy_in"}, 64'(m_ready_in), 64'd0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
    endtask

    // Output monitor: scoreboard, stall stability, keep_err pulse and packet count.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("keep_err", 64'(m_err), 64'(exp_err));
                chk("pkt_cnt", 64'(m_pkt), 64'(16'(model_cnt)));
                if (stalled) chk("stall_hold", {m_vo, m_lo, m_ko, m_do[53:0]}, {1'b1, hold_l, hold_k, hold_d[53:0]});
                if (stalled) chk("stall_hold_hi", m_do, hold_d);
                if (m_vo && ready_out) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL extra_beat got %h exp none", m_do);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_do, e.data);
                        chk("beat_keep_last", {55'd0, m_lo, m_ko}, {55'd0, e.last, e.keep});
                        if (e.last) model_cnt++;
                    end
                end
                stalled = m_vo && !ready_out;
                hold_d  = m_do;
                hold_k  = m_ko;
                hold_l  = m_lo;
            end else begin
                stalled = 1'b0;
            end
            exp_err = rst_n && valid_in && m_ready_in && bad_keep(keep_in, last_in, nb);
        end
    end

    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; valid_in = 1'b0; last_in = 1'b0; valid_insert = 1'b0;
        data_in = '0; data_insert = '0; keep_in = '0; keep_insert = '0; byte_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("w32");

        push_exp(64'hAABB1122, 8'hF, 1'b0);
        push_exp(64'h33445566, 8'hF, 1'b0);
        push_exp(64'h77880000, 8'hC, 1'b1);
        send_hdr(64'hFFFF_AABB, 2);
        send_beat(64'h11223344, 8'hF, 1'b0);
        send_beat(64'h55667788, 8'hF, 1'b1);
        drain("drain_h2");
        chk("pkt_h2", 64'(m_pkt), 64'd1);

        push_exp(64'hDEADBEEF, 8'hF, 1'b0);
        push_exp(64'h01020304, 8'hF, 1'b1);
        send_hdr(64'hDEADBEEF, 4);
        send_beat(64'h01020304, 8'hF, 1'b1);

        push_exp(64'hA1B2C344, 8'hF, 1'b1);
        send_hdr(64'h00A1B2C3, 3);
        send_beat(64'h44000000, 8'h8, 1'b1);

        push_exp(64'hCCDD9900, 8'hE, 1'b1);
        send_hdr(64'h0000CCDD, 2);
        send_beat(64'h99AA55BB, 8'hA, 1'b1);
        drain("drain_dir");
        chk("pkt_dir", 64'(m_pkt), 64'd4);

        rnd_ready = 1'b1;
        beats = 0;
        while (beats < 50) rand_pkt(0);
        drain("drain_rand32");

        mon_en = 1'b0;
        send_hdr({$urandom, $urandom}, 3);
        send_beat({$urandom, $urandom}, 8'hF, 1'b0);
        do_reset("abort32");
        rand_pkt(0);
        drain("drain_after_abort32");
        chk("pkt_after_abort32", 64'(m_pkt), 64'd1);

        sel = 1'b1;
        nb  = 8;
        do_reset("w64");
        for (int i = 0; i < 12; i++) rand_pkt((i % 3 == 0) ? 5 : 0);
        drain("drain_rand64");
        chk("pkt_rand64", 64'(m_pkt), 64'd12);

        mon_en = 1'b0;
        send_hdr({$urandom, $urandom}, 5);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        do_reset("abort64");
        rand_pkt(5);
        drain("drain_after_abort64");
        chk("pkt_after_abort64", 64'(m_pkt), 64'd1);

        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
